// File: rtl/comparador_serial_pkg.sv
// rtl/comparador_serial_pkg.sv - shared encodings for the serial magnitude comparator
// Purpose: accumulator codes, FSM state codes and scan-direction codes
//          used by comparador_serial and comparador_digito.
// Ports:   none (package).
package comparador_serial_pkg;

  // Running comparison result carried from digit to digit.
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Controller states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Scan direction: DI = right-to-left (LSB first), ID = left-to-right (MSB first).
  localparam logic MODE_DI = 1'b0;
  localparam logic MODE_ID = 1'b1;

endpackage

// File: rtl/comparador_digito.sv
// rtl/comparador_digito.sv - one iterative comparator cell, reused once per clock
// Purpose: folds one D-bit digit pair into the running comparison result.
// Ports:   digit_a, digit_b - D-bit digits of operands A and B
//          acc_in           - result accumulated so far (CMP_*)
//          mode             - MODE_DI (LSB first) or MODE_ID (MSB first)
//          acc_out          - updated result
module comparador_digito
  import comparador_serial_pkg::*;
#(
  parameter int D = 1
) (
  input  logic [D-1:0] digit_a,
  input  logic [D-1:0] digit_b,
  input  logic [1:0]   acc_in,
  input  logic         mode,
  output logic [1:0]   acc_out
);

  always_comb begin
    acc_out = acc_in;
    // LSB-first: every more significant mismatch overrides the earlier result.
    // MSB-first: only the first mismatch counts; later digits are less significant.
    if (digit_a != digit_b) begin
      if (mode == MODE_DI || acc_in == CMP_EQ) begin
        acc_out = (digit_a > digit_b) ? CMP_GT : CMP_LT;
      end
    end
  end

endmodule

// File: rtl/comparador_serial.sv
// rtl/comparador_serial.sv - serial magnitude comparator, D bits per clock
// Purpose: compares two W-bit operands digit by digit under a start/done
//          handshake. Optional macro COMPARADOR_SERIAL_SIGNED_EN treats the
//          operands as two's complement (unsigned when undefined).
// Ports:   clk, reset     - clock, synchronous active-high reset
//          start          - request, accepted in IDLE or DONE
//          mode           - 0 LSB first, 1 MSB first with early exit
//          a, b           - operands, latched with start
//          busy, done     - busy in RUN/DONE, done one-cycle pulse
//          gt, eq, lt     - held result flags
//          cycles         - digits processed for the last result
module comparador_serial
  import comparador_serial_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int D  = 1,
  localparam int N  = W / D,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mode,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          busy,
  output logic          done,
  output logic          gt,
  output logic          eq,
  output logic          lt,
  output logic [CW-1:0] cycles
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          mode_q, mode_d;
  logic [1:0]    acc_q, acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;

  logic [W-1:0]  a_lat, b_lat;
  logic [D-1:0]  dig_a, dig_b;
  logic [1:0]    acc_next;
  logic          last;

`ifdef COMPARADOR_SERIAL_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [W-1:0] SIGN_MASK = W'(1) << (W - 1);
  assign a_lat = a ^ SIGN_MASK;
  assign b_lat = b ^ SIGN_MASK;
`else
  assign a_lat = a;
  assign b_lat = b;
`endif

  assign dig_a = a_q[idx_q*D +: D];
  assign dig_b = b_q[idx_q*D +: D];

  comparador_digito #(.D(D)) u_celda (
    .digit_a (dig_a),
    .digit_b (dig_b),
    .acc_in  (acc_q),
    .mode    (mode_q),
    .acc_out (acc_next)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    cycles_d = cycles_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    last     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d      = a_lat;
          b_d      = b_lat;
          mode_d   = mode;
          acc_d    = CMP_EQ;
          idx_d    = (mode == MODE_ID) ? IDX_LAST : '0;
          cycles_d = '0;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d    = acc_next;
        cycles_d = cycles_q + CW'(1);
        // MSB-first stops at the first mismatch; LSB-first always walks all N digits.
        if (mode_q == MODE_DI) begin
          last = (idx_q == IDX_LAST);
        end else begin
          last = (idx_q == '0) || (acc_next != CMP_EQ);
        end
        if (last) begin
          state_d = ST_DONE;
          gt_d    = (acc_next == CMP_GT);
          eq_d    = (acc_next == CMP_EQ);
          lt_d    = (acc_next == CMP_LT);
        end else begin
          idx_d = (mode_q == MODE_DI) ? idx_q + IW'(1) : idx_q - IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= MODE_DI;
      acc_q    <= CMP_EQ;
      idx_q    <= '0;
      cycles_q <= '0;
      gt_q     <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      cycles_q <= cycles_d;
      gt_q     <= gt_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign gt     = gt_q;
  assign eq     = eq_q;
  assign lt     = lt_q;
  assign cycles = cycles_q;

endmodule

// File: doc/comparador_serial.md
Name: comparador_serial

Overview:
- Sequential successor to the combinational iterative magnitude comparator: the same cell-by-cell comparison, executed over time.
- Compares two W-bit operands D bits per clock, so area does not scale with W.
- Runs either right-to-left (LSB first) or left-to-right (MSB first, with early termination).
- Sits beside the combinational comparator networks and is driven by a start/done handshake from a controlling FSM.

Parameters:
W, 8, operand width in bits; must be a multiple of D
D, 1, bits (digit width) compared per clock; 1 <= D <= W
N, W/D (derived localparam), digits per operand
CW, $clog2(N+1) (derived localparam), width of cycles output

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
mode  input  1  0 = right-to-left (LSB first), 1 = left-to-right (MSB first, early exit); latched with start
a  input  W  operand A; latched with start
b  input  W  operand B; latched with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result valid
gt  output  1  A > B; held until next accepted start
eq  output  1  A == B; held
lt  output  1  A < B; held
cycles  output  CW  digits processed for last result; held

Behaviour:
- Reset (sync, active-high, priority over all): state=IDLE; busy=0, done=0, gt=0, eq=0, lt=0, cycles=0; internal registers cleared. Applies mid-operation; the pending comparison is dropped and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches a, b and mode, clears the accumulator to EQ, sets idx (0 for mode 0, N-1 for mode 1), clears cycles, then goes to RUN. start=0 keeps IDLE.
- RUN, one digit per edge; a digit is the D-bit slice [idx*D +: D].
- RUN, mode 0: if digit_a != digit_b, acc = (digit_a > digit_b) ? GT : LT; otherwise acc is unchanged. idx++. Higher digits override lower ones. Always exactly N digits.
- RUN, mode 1: if acc == EQ and digit_a != digit_b, acc is set to GT or LT. idx--. The FSM exits to DONE on the first mismatch or after digit 0.
- Each RUN edge increments cycles. On exit, gt/eq/lt load from the final acc in the same edge that enters DONE.
- DONE lasts exactly one cycle: done=1, busy=1. If start=1, the new operands are accepted (back-to-back) and the FSM goes to RUN; otherwise it goes to IDLE.
- Latency, counted from the edge sampling start to the edge after which done=1:
  - mode 0: N edges.
  - mode 1: k edges, where k is the 1-based position of the first mismatching digit from the MSB; N edges if A == B.
- start in RUN is ignored. a, b and mode may change freely after acceptance.
- Exactly one of gt/eq/lt is high after the first done; all are 0 after reset until then.
- D == W: N=1; every operation takes 1 RUN cycle.

Optional Feature:
- Macro: COMPARADOR_SERIAL_SIGNED_EN.
- Defined: operands are two's complement. The sign bit (bit W-1) is inverted on both operands at latch time, then the unsigned algorithm runs unchanged. Result and latency rules are otherwise identical.
- Undefined: operands are unsigned.

Decomposition:
- Shared include/package holds:
  - acc encoding: CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10.
  - FSM codes: ST_IDLE, ST_RUN, ST_DONE.
  - MODE_DI=0, MODE_ID=1.
- One combinational sub-module, comparador_digito (parameter D).
  - Inputs: D-bit digit_a, digit_b; 2-bit acc_in; mode.
  - Output: acc_out, per the RUN rules above.
  - It is the iterative cell, reused once per clock.

Test Plan:
- W=8, D=1, mode 0, a=8'h5A, b=8'h5A -> done N=8 edges after start; eq=1, gt=lt=0, cycles=8.
- W=8, D=1, mode 1, a=8'h80, b=8'h7F -> mismatch at MSB; done 1 edge after start; gt=1, cycles=1. Same operands in mode 0 -> gt=1, cycles=8.
- W=8, D=2, mode 1, a=8'h1C, b=8'h1E -> digit 0 differs (2'b00 vs 2'b10); done after 4 edges; lt=1, cycles=4.
- Back-to-back: assert start during DONE with a=3, b=9 (W=8, D=4, mode 0) -> no IDLE cycle; second done 2 edges later; lt=1. start pulsed during RUN -> ignored; no extra done.
- Reset mid-RUN (edge 3 of 8) -> next cycle busy=0, gt=eq=lt=0; no done pulse. A following start completes normally.
- COMPARADOR_SERIAL_SIGNED_EN defined, W=8, a=8'hFF (-1), b=8'h01 -> lt=1. Macro undefined, same operands -> gt=1.
